bp_be_lce_resp_credit_unit: RTL

- Parametrised LCE-side response arbiter and outstanding-request credit tracker.
- Merges N LCE response sources onto one LCE->CCE response channel.
- Arbitration is fixed-priority or round-robin. The output is registered through a 2-entry buffer, so resp_o and resp_v_o do not depend combinationally on the inputs.
- Counts in-flight coherence requests and retires up to R credit-return events per cycle.
- Sits between the dcache LCE request/command engines and the coherence NoC.

---
 rtl/bp_be_lce_resp_credit_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/bp_be_lce_resp_credit_unit.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_lce_resp_credit_unit
// Purpose  : LCE-side response arbiter (fixed-priority or round-robin) feeding
//            a 2-entry registered output buffer, plus an outstanding-request
//            credit counter with clamping.
// Options  : define BP_BE_LCE_CREDIT_ERR_EN to build the sticky credit
//            overflow/underflow flag; otherwise credit_err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_lce_resp_credit_unit #(
    parameter int num_src_p     = 2,
    parameter int resp_width_p  = 64,
    parameter int max_credits_p = 8,
    parameter int num_return_p  = 4,
    parameter int rr_mode_p     = 0
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_src_p*resp_width_p-1:0]   src_resp_i,
    input  logic [num_src_p-1:0]                src_v_i,
    output logic [num_src_p-1:0]                src_yumi_o,
    output logic [resp_width_p-1:0]             resp_o,
    output logic                                resp_v_o,
    input  logic                                resp_ready_i,
    input  logic                                req_v_i,
    input  logic                                req_ready_i,
    input  logic [num_return_p-1:0]             credit_return_i,
    output logic [$clog2(max_credits_p+1)-1:0]  credit_count_o,
    output logic                                credits_full_o,
    output logic                                credits_empty_o,
    output logic                                credit_err_o
);

    localparam int PW    = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    localparam int CW    = $clog2(max_credits_p + 1);
    localparam int RW    = $clog2(num_return_p + 1);
    localparam int RAW_W = CW + RW + 1;

    localparam logic [PW-1:0]           PTR_RESET = PW'(num_src_p - 1);
    localparam logic signed [RAW_W-1:0] MAX_S     = RAW_W'(max_credits_p);
    localparam logic [CW-1:0]           MAX_C     = CW'(max_credits_p);

    // ------------------------------------------------------------------
    // Output buffer state
    // ------------------------------------------------------------------
    logic [resp_width_p-1:0] mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              occ;

    logic                    pop;
    logic                    can_push;
    logic                    push;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           grant_idx;
    logic                    grant_v;
    int                      cand;
    logic [num_src_p-1:0]    grant_oh;
    logic [resp_width_p-1:0] grant_pkt;

    assign resp_v_o = (occ != 2'd0);
    assign pop      = resp_v_o & resp_ready_i;
    // A full buffer can still accept when its head leaves this cycle.
    assign can_push = (occ != 2'd2) | pop;
    assign push     = grant_v & can_push;

    assign resp_o     = resp_v_o ? mem[rd_ptr] : '0;
    assign src_yumi_o = push ? grant_oh : '0;

    // Pick the winning source: lowest index, or first valid after rr_ptr.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 0; i < num_src_p; i++) begin
            if (rr_mode_p != 0) begin
                cand = int'(rr_ptr) + 1 + i;
                if (cand >= num_src_p) cand = cand - num_src_p;
            end else begin
                cand = i;
            end
            if (!grant_v && src_v_i[cand]) begin
                grant_v   = 1'b1;
                grant_idx = PW'(cand);
            end
        end
    end

    // Decode the winner to one-hot and select its packet.
    always_comb begin
        grant_oh  = '0;
        grant_pkt = '0;
        for (int k = 0; k < num_src_p; k++) begin
            if (grant_v && (grant_idx == PW'(k))) begin
                grant_oh[k] = 1'b1;
                grant_pkt   = src_resp_i[k*resp_width_p +: resp_width_p];
            end
        end
    end

    // Round-robin pointer follows the last granted source.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr <= PTR_RESET;
        end else if (push && (rr_mode_p != 0)) begin
            rr_ptr <= grant_idx;
        end
    end

    // Two-entry FIFO: push the granted packet, pop when downstream is ready.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= grant_pkt;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Credit counter
    // ------------------------------------------------------------------
    logic                    inc;
    logic [RW-1:0]           dec;
    logic signed [RAW_W-1:0] raw;
    logic                    over;
    logic                    under;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_nxt;

    assign inc = req_v_i & req_ready_i;

    // Count returned credits this cycle.
    always_comb begin
        dec = '0;
        for (int j = 0; j < num_return_p; j++) begin
            dec = dec + RW'(credit_return_i[j]);
        end
    end

    // Signed net update wide enough that neither direction wraps, then clamp.
    always_comb begin
        raw = $signed({{(RAW_W-CW){1'b0}}, count})
            + $signed({{(RAW_W-1){1'b0}}, inc})
            - $signed({{(RAW_W-RW){1'b0}}, dec});
        over  = (raw > MAX_S);
        under = raw[RAW_W-1];
        if (over) begin
            count_nxt = MAX_C;
        end else if (under) begin
            count_nxt = '0;
        end else begin
            count_nxt = raw[CW-1:0];
        end
    end

    // Register the clamped count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    assign credit_count_o  = count;
    assign credits_full_o  = (count == MAX_C);
    assign credits_empty_o = (count == '0);

`ifdef BP_BE_LCE_CREDIT_ERR_EN
    logic err;

    // Sticky flag: any clamp event latches until reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err <= 1'b0;
        end else if (over || under) begin
            err <= 1'b1;
        end
    end

    assign credit_err_o = err;
`else
    assign credit_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
